// File: rtl/multicycle_control_if.sv
// Opcode handshake, datapath control and hold handshake bundle for multicycle_control.
interface multicycle_control_if #(
    parameter int OP_W  = 6,
    parameter int ALU_W = 4
);
    logic             op_valid;
    logic [OP_W-1:0]  op;
    logic             op_ready;
    logic             reg_dest;
    logic             alu_src;
    logic             mem_to_reg;
    logic [ALU_W-1:0] alu_ctrl;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             hold;
    logic             unhold;
    logic             illegal;
    logic             timeout;

    modport master (
        output op_valid, op, unhold,
        input  op_ready, reg_dest, alu_src, mem_to_reg, alu_ctrl,
               reg_write, mem_read, mem_write, branch, jump, hold, illegal, timeout
    );

    modport slave (
        input  op_valid, op, unhold,
        output op_ready, reg_dest, alu_src, mem_to_reg, alu_ctrl,
               reg_write, mem_read, mem_write, branch, jump, hold, illegal, timeout
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control unit: accepts one opcode and sequences it with registered strobes.
// Define CTRL_HOLD_TIMEOUT_EN to abort MEM/SYS holds after HOLD_TIMEOUT cycles.
module multicycle_control #(
    parameter int OP_W         = 6,
    parameter int ALU_W        = 4,
    parameter int HOLD_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.slave  bus
);
    // state  | meaning
    // IDLE   | waiting for an opcode
    // DECODE | opcode latched, selects and alu_ctrl registered
    // EXEC   | ALU phase, branch/jump strobes
    // MEM    | memory access, held until unhold
    // WB     | register write-back
    // SYS    | system instruction, held until unhold
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_SYS} state_t;
    typedef enum logic [2:0] {
        C_RTYPE, C_ADDI, C_LOAD, C_STORE, C_BEQ, C_JUMP, C_SYS, C_ILLEGAL
    } cls_t;

    if (HOLD_TIMEOUT < 2 || OP_W < 5 || ALU_W < 3) begin : g_bad_param
        $error("multicycle_control: parameter out of range");
    end

    state_t           state, next_state;
    cls_t             cls;
    logic [OP_W-1:0]  op_q;
    logic             accept;

    logic             op_ready_q, op_ready_d;
    logic             reg_dest_q, reg_dest_d;
    logic             alu_src_q, alu_src_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic [ALU_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             branch_q, branch_d;
    logic             jump_q, jump_d;
    logic             hold_q, hold_d;
    logic             illegal_q, illegal_d;

`ifdef CTRL_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;
    logic             timeout_q;
`endif

    assign accept = bus.op_valid && op_ready_q;

    always_comb begin
        cls = C_ILLEGAL;
        case (op_q)
            OP_W'(0), OP_W'(1), OP_W'(2), OP_W'(3), OP_W'(4): cls = C_RTYPE;
            OP_W'(5):                                          cls = C_ADDI;
            OP_W'(10), OP_W'(11):                              cls = C_LOAD;
            OP_W'(12), OP_W'(13), OP_W'(14):                   cls = C_STORE;
            OP_W'(20):                                         cls = C_BEQ;
            OP_W'(21):                                         cls = C_JUMP;
            OP_W'(30), OP_W'(31):                              cls = C_SYS;
            default:                                           cls = C_ILLEGAL;
        endcase
    end

    // Outputs are computed from the current state and registered, so each phase
    // becomes visible one cycle after the state is entered.
    always_comb begin
        next_state   = state;
        op_ready_d   = 1'b0;
        reg_dest_d   = reg_dest_q;
        alu_src_d    = alu_src_q;
        mem_to_reg_d = mem_to_reg_q;
        alu_ctrl_d   = alu_ctrl_q;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        hold_d       = 1'b0;
        illegal_d    = 1'b0;
`ifdef CTRL_HOLD_TIMEOUT_EN
        cnt_d        = CNT_W'(HOLD_TIMEOUT - 1);
        expired_d    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                reg_dest_d   = 1'b0;
                alu_src_d    = 1'b0;
                mem_to_reg_d = 1'b0;
                alu_ctrl_d   = '0;
                op_ready_d   = !accept;
                if (accept) next_state = S_DECODE;
            end
            S_DECODE: begin
                reg_dest_d   = 1'b0;
                alu_src_d    = 1'b0;
                mem_to_reg_d = 1'b0;
                alu_ctrl_d   = '0;
                next_state   = S_EXEC;
                case (cls)
                    C_RTYPE: begin
                        reg_dest_d = 1'b1;
                        alu_ctrl_d = ALU_W'(op_q[2:0]);
                    end
                    C_ADDI:  alu_src_d = 1'b1;
                    C_LOAD: begin
                        alu_src_d    = 1'b1;
                        mem_to_reg_d = 1'b1;
                    end
                    C_STORE: alu_src_d = 1'b1;
                    C_BEQ:   alu_ctrl_d = ALU_W'(1);
                    C_SYS:   next_state = S_SYS;
                    C_ILLEGAL: begin
                        illegal_d  = 1'b1;
                        next_state = S_IDLE;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                branch_d = (cls == C_BEQ);
                jump_d   = (cls == C_JUMP);
                case (cls)
                    C_LOAD, C_STORE: next_state = S_MEM;
                    C_RTYPE, C_ADDI: next_state = S_WB;
                    default:         next_state = S_IDLE;
                endcase
            end
            S_MEM, S_SYS: begin
                hold_d      = 1'b1;
                mem_read_d  = (state == S_MEM) && (cls == C_LOAD);
                mem_write_d = (state == S_MEM) && (cls == C_STORE);
                if (bus.unhold)
                    next_state = (state == S_MEM && cls == C_LOAD) ? S_WB : S_IDLE;
`ifdef CTRL_HOLD_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    // Aborted: skip WB so no register write follows
                    next_state = S_IDLE;
                    expired_d  = 1'b1;
                end
                cnt_d = cnt_q - CNT_W'(1);
`endif
            end
            S_WB: begin
                reg_write_d = 1'b1;
                next_state  = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= '0;
            op_ready_q   <= 1'b1;
            reg_dest_q   <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_ctrl_q   <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            hold_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            if (accept) op_q <= bus.op;
            op_ready_q   <= op_ready_d;
            reg_dest_q   <= reg_dest_d;
            alu_src_q    <= alu_src_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_ctrl_q   <= alu_ctrl_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            hold_q       <= hold_d;
            illegal_q    <= illegal_d;
        end
    end

`ifdef CTRL_HOLD_TIMEOUT_EN
    // timeout lands with op_ready, one cycle after the last hold cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
            timeout_q <= expired_q;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.op_ready   = op_ready_q;
    assign bus.reg_dest   = reg_dest_q;
    assign bus.alu_src    = alu_src_q;
    assign bus.mem_to_reg = mem_to_reg_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.branch     = branch_q;
    assign bus.jump       = jump_q;
    assign bus.hold       = hold_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a cycle-timeline model of each instruction class.
module tb_multicycle_control;
    localparam int OP_W = 6;
    localparam int ALU_W = 4;
    localparam int HOLD_TIMEOUT = 4;
`ifdef CTRL_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int C_R = 0, C_ADDI = 1, C_LD = 2, C_ST = 3, C_BEQ = 4, C_JMP = 5, C_SYS = 6, C_ILL = 7;

    typedef struct packed {
        logic             op_ready;
        logic             reg_dest;
        logic             alu_src;
        logic             mem_to_reg;
        logic [ALU_W-1:0] alu_ctrl;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic             jump;
        logic             hold;
        logic             illegal;
        logic             timeout;
    } outs_t;

    logic  clk = 1'b0;
    logic  rst;
    outs_t exp_o;
    outs_t got_o;
    bit    chk = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    int    cur_op = -1;

    always #5 clk = ~clk;

    multicycle_control_if #(.OP_W(OP_W), .ALU_W(ALU_W)) bus ();

    multicycle_control #(.OP_W(OP_W), .ALU_W(ALU_W), .HOLD_TIMEOUT(HOLD_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int cls_of(int opv);
        case (opv)
            0, 1, 2, 3, 4: return C_R;
            5:             return C_ADDI;
            10, 11:        return C_LD;
            12, 13, 14:    return C_ST;
            20:            return C_BEQ;
            21:            return C_JMP;
            30, 31:        return C_SYS;
            default:       return C_ILL;
        endcase
    endfunction

    // Accept edge is cycle 0; m is the number of MEM/SYS cycles, to marks a timed-out hold.
    function automatic int latency(int c, int m, bit to);
        case (c)
            C_R, C_ADDI:  return 4;
            C_LD:         return to ? 3 + m : 4 + m;
            C_ST:         return 3 + m;
            C_BEQ, C_JMP: return 3;
            C_SYS:        return 2 + m;
            default:      return 2;
        endcase
    endfunction

    function automatic outs_t idle_o();
        outs_t o = '0;
        o.op_ready = 1'b1;
        return o;
    endfunction

    function automatic outs_t model(int c, int opv, int k, int m, bit to);
        outs_t o = '0;
        int    lat = latency(c, m, to);
        int    hold_first = (c == C_SYS) ? 2 : 3;
        bit    in_hold;
        if (k >= lat) begin
            o = idle_o();
            o.timeout = to;
            return o;
        end
        if (k == 0) return o;
        case (c)
            C_R:    begin o.reg_dest = 1'b1; o.alu_ctrl = ALU_W'(opv); end
            C_ADDI: o.alu_src = 1'b1;
            C_LD:   begin o.alu_src = 1'b1; o.mem_to_reg = 1'b1; end
            C_ST:   o.alu_src = 1'b1;
            C_BEQ:  o.alu_ctrl = ALU_W'(1);
            C_ILL:  o.illegal = (k == 1);
            default: ;
        endcase
        in_hold     = (c == C_LD || c == C_ST || c == C_SYS) && k >= hold_first && k < hold_first + m;
        o.hold      = in_hold;
        o.mem_read  = in_hold && c == C_LD;
        o.mem_write = in_hold && c == C_ST;
        o.branch    = (c == C_BEQ) && k == 2;
        o.jump      = (c == C_JMP) && k == 2;
        o.reg_write = ((c == C_R || c == C_ADDI) && k == 3) || (c == C_LD && !to && k == 3 + m);
        return o;
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            got_o = {bus.op_ready, bus.reg_dest, bus.alu_src, bus.mem_to_reg, bus.alu_ctrl,
                     bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump,
                     bus.hold, bus.illegal, bus.timeout};
            vectors++;
            if (got_o !== exp_o) begin
                miscompares++;
                $display("FAIL outputs t=%0t op=%0d got=%b want=%b", $time, cur_op, got_o, exp_o);
            end
        end
    end

    task automatic pin(string name, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL model_%s got=%0d want=%0d", name, got, want);
        end
    endtask

    // d: MEM/SYS cycles before unhold; rst_at: cycle at which to assert rst (-1 for none)
    task automatic do_instr(int opv, int d, int gap, int rst_at);
        int  c = cls_of(opv);
        bit  is_hold = (c == C_LD || c == C_ST || c == C_SYS);
        int  start = (c == C_SYS) ? 1 : 2;
        int  m = 0;
        bit  to = 1'b0;
        int  lat;
        if (is_hold) begin
            if (TO_EN && d >= HOLD_TIMEOUT) begin
                m  = HOLD_TIMEOUT;
                to = 1'b1;
            end else begin
                m = d + 1;
            end
        end
        lat = latency(c, m, to);
        for (int g = 0; g < gap; g++) begin
            bus.op_valid = 1'b0;
            bus.op       = OP_W'($urandom);
            bus.unhold   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            exp_o = idle_o();
        end
        cur_op       = opv;
        bus.op_valid = 1'b1;
        bus.op       = OP_W'(opv);
        bus.unhold   = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            exp_o = model(c, opv, k, m, to);
            bus.op_valid = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.op       = OP_W'($urandom);
            if (is_hold && k >= start && k < start + m)
                bus.unhold = !to && (k == start + m - 1);
            else
                bus.unhold = 1'($urandom_range(0, 1));
            if (k == rst_at) begin
                rst          = 1'b1;
                bus.unhold   = 1'b1;
                bus.op_valid = 1'b0;
                @(posedge clk); #1;
                rst   = 1'b0;
                exp_o = idle_o();
                for (int j = 0; j < 3; j++) begin
                    bus.unhold = 1'b1;
                    @(posedge clk); #1;
                    exp_o = idle_o();
                end
                bus.unhold = 1'b0;
                return;
            end
        end
    endtask

    int legal[15] = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 13, 14, 20, 21, 30, 31};

    initial begin
        outs_t pinned;
        int    opv;
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.op       = '0;
        bus.unhold   = 1'b0;
        exp_o        = idle_o();

        pin("lat_add", latency(cls_of(0), 0, 1'b0), 4);
        pin("lat_ldw", latency(cls_of(11), 1, 1'b0), 5);
        pin("lat_ldw_hold3", latency(cls_of(11), 3, 1'b0), 7);
        pin("lat_stw", latency(cls_of(13), 1, 1'b0), 4);
        pin("lat_beq", latency(cls_of(20), 0, 1'b0), 3);
        pin("lat_sys", latency(cls_of(31), 1, 1'b0), 3);
        pin("lat_ill", latency(cls_of(7), 0, 1'b0), 2);
        pin("cls_mov", cls_of(14), C_ST);
        pinned = model(C_R, 0, 3, 0, 1'b0);
        pin("add_wb", int'(pinned.reg_write), 1);
        pinned = model(C_LD, 11, 6, 3, 1'b0);
        pin("ldw_wb_m2r", int'({pinned.reg_write, pinned.mem_to_reg}), 3);

        repeat (3) @(posedge clk);
        #1;
        exp_o = idle_o();
        chk   = 1'b1;
        rst   = 1'b0;

        do_instr(0, 0, 1, -1);
        do_instr(11, 2, 0, -1);
        do_instr(20, 0, 1, -1);
        do_instr(13, 1, 0, -1);
        do_instr(7, 0, 1, -1);
        do_instr(63, 0, 0, -1);
        do_instr(12, 5, 1, 3);
        do_instr(4, 0, 0, -1);
`ifdef CTRL_HOLD_TIMEOUT_EN
        do_instr(30, 10, 1, -1);
        do_instr(30, HOLD_TIMEOUT - 1, 0, -1);
        do_instr(11, 10, 0, -1);
`endif
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) opv = int'($urandom_range(0, 63));
            else                            opv = legal[$urandom_range(0, 14)];
            do_instr(opv, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), -1);
        end

        @(negedge clk);
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
